tr_dual_port_mem: RTL and testbench



---
 rtl/tr_mem_pkg.sv | 48 ++++
 rtl/tr_dual_port_mem_resp_pipe.sv | 32 +++
 rtl/tr_dual_port_mem.sv | 194 +++++++++++++++++++
 tb/tb_tr_dual_port_mem.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tr_mem_pkg.sv
// Shared types and helpers for the dual-port TestRIG memory responder.
// Response record, address-range check and byte-lane/tag write rule.
package tr_mem_pkg;

    localparam int unsigned TR_WORD_W = 33;
    localparam int unsigned TR_CNT_W  = 4;

    typedef struct packed {
        logic                 valid;
        logic                 err;
        logic [TR_WORD_W-1:0] rdata;
    } tr_resp_t;

    // Widened to 34 bits so a window ending at 2^32 does not wrap.
    function automatic logic tr_in_range(
        input logic [31:0]  addr,
        input logic [31:0]  base,
        input int unsigned  depth
    );
        logic [33:0] a_w;
        logic [33:0] lo_w;
        logic [33:0] hi_w;
        a_w  = {2'b00, addr};
        lo_w = {2'b00, base};
        hi_w = lo_w + (34'(depth) << 2);
        return (a_w >= lo_w) && (a_w < hi_w);
    endfunction

    // Bit 32 is the capability tag: only a full-word write may set it.
    function automatic logic [TR_WORD_W-1:0] tr_apply_be(
        input logic [TR_WORD_W-1:0] old,
        input logic [TR_WORD_W-1:0] wdata,
        input logic [3:0]           be
    );
        logic [TR_WORD_W-1:0] res;
        res = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[i*8 +: 8] = wdata[i*8 +: 8];
            end else begin
                res[i*8 +: 8] = old[i*8 +: 8];
            end
        end
        res[32] = (be == 4'hF) ? wdata[32] : 1'b0;
        return res;
    endfunction

endpackage

// File: rtl/tr_dual_port_mem_resp_pipe.sv
// Fixed-latency response delay line; one instance per port.
// No backpressure: whatever enters leaves exactly Latency edges later.
module tr_resp_pipe
    import tr_mem_pkg::*;
#(
    parameter int unsigned Latency = 1
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  tr_resp_t resp_i,
    output tr_resp_t resp_o
);

    tr_resp_t stage_q [Latency];

    // Shift responses one stage per cycle; reset drops everything in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Latency; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= resp_i;
            for (int i = 1; i < Latency; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign resp_o = stage_q[Latency-1];

endmodule

// File: rtl/tr_dual_port_mem.sv
// Dual-port behavioural memory answering the instruction and data OBI ports
// from one shared array, with latency, outstanding limit and error counting.
module tr_dual_port_mem
    import tr_mem_pkg::*;
#(
    parameter logic [31:0] BaseAddr       = 32'h8000_0000,
    parameter int unsigned Depth          = 16384,
    parameter int unsigned DataWidth      = 33,
    parameter int unsigned RespLatency    = 1,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 instr_stall_i,
    input  logic                 data_stall_i,
    input  logic                 instr_req_i,
    output logic                 instr_gnt_o,
    output logic                 instr_rvalid_o,
    input  logic [31:0]          instr_addr_i,
    output logic [31:0]          instr_rdata_o,
    output logic                 instr_err_o,
    input  logic                 data_req_i,
    output logic                 data_gnt_o,
    output logic                 data_rvalid_o,
    input  logic                 data_we_i,
    input  logic [3:0]           data_be_i,
    input  logic [31:0]          data_addr_i,
    input  logic [DataWidth-1:0] data_wdata_i,
    output logic [DataWidth-1:0] data_rdata_o,
    output logic                 data_err_o,
    output logic [15:0]          err_count_o
);

    localparam int unsigned         IdxW   = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [TR_CNT_W-1:0] MaxOut = TR_CNT_W'(MaxOutstanding);
    localparam logic [TR_CNT_W-1:0] CntOne = TR_CNT_W'(1);

    logic [DataWidth-1:0] mem [Depth];

    logic                 instr_acc_s;
    logic                 instr_inr_s;
    logic [IdxW-1:0]      instr_idx_s;
    tr_resp_t             instr_resp_d;
    tr_resp_t             instr_pipe_s;
    logic [TR_CNT_W-1:0]  instr_cnt_d;
    logic [TR_CNT_W-1:0]  instr_cnt_q;

    logic                 data_acc_s;
    logic                 data_inr_s;
    logic                 data_wr_s;
    logic [IdxW-1:0]      data_idx_s;
    logic [TR_WORD_W-1:0] data_old_s;
    logic [TR_WORD_W-1:0] data_wext_s;
    logic [TR_WORD_W-1:0] data_new_s;
    tr_resp_t             data_resp_d;
    tr_resp_t             data_pipe_s;
    logic [TR_CNT_W-1:0]  data_cnt_d;
    logic [TR_CNT_W-1:0]  data_cnt_q;

    logic [1:0]           err_inc_s;
    logic [16:0]          err_sum_s;
    logic [15:0]          err_count_d;
    logic [15:0]          err_count_q;
    logic                 rdata_unused_s;

    assign instr_gnt_o = instr_req_i & ~instr_stall_i & (instr_cnt_q < MaxOut);
    assign data_gnt_o  = data_req_i & ~data_stall_i & (data_cnt_q < MaxOut);
    assign instr_acc_s = instr_req_i & instr_gnt_o;
    assign data_acc_s  = data_req_i & data_gnt_o;

    assign instr_inr_s = tr_in_range(instr_addr_i, BaseAddr, Depth);
    assign data_inr_s  = tr_in_range(data_addr_i, BaseAddr, Depth);
    assign instr_idx_s = IdxW'((instr_addr_i - BaseAddr) >> 2);
    assign data_idx_s  = IdxW'((data_addr_i - BaseAddr) >> 2);

    assign data_old_s  = TR_WORD_W'(mem[data_idx_s]);
    assign data_wext_s = TR_WORD_W'(data_wdata_i);
    assign data_new_s  = tr_apply_be(data_old_s, data_wext_s, data_be_i);
    assign data_wr_s   = data_acc_s & data_we_i & data_inr_s;

    // Instruction response: read samples the array in the accept cycle.
    always_comb begin
        instr_resp_d = '0;
        if (instr_acc_s) begin
            instr_resp_d.valid = 1'b1;
            instr_resp_d.err   = ~instr_inr_s;
            if (instr_inr_s) begin
                instr_resp_d.rdata = TR_WORD_W'(mem[instr_idx_s]);
            end else begin
                instr_resp_d.rdata = '0;
            end
        end else begin
            instr_resp_d = '0;
        end
    end

    // Data response: writes and out-of-range accesses return zero data.
    always_comb begin
        data_resp_d = '0;
        if (data_acc_s) begin
            data_resp_d.valid = 1'b1;
            data_resp_d.err   = ~data_inr_s;
            if (data_inr_s && !data_we_i) begin
                data_resp_d.rdata = data_old_s;
            end else begin
                data_resp_d.rdata = '0;
            end
        end else begin
            data_resp_d = '0;
        end
    end

    // Array write; sampling rst_ni discards a write that coincides with reset.
    always_ff @(posedge clk_i) begin
        if (rst_ni && data_wr_s) begin
            mem[data_idx_s] <= data_new_s[DataWidth-1:0];
        end
    end

    tr_resp_pipe #(
        .Latency (RespLatency)
    ) u_instr_pipe (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .resp_i (instr_resp_d),
        .resp_o (instr_pipe_s)
    );

    tr_resp_pipe #(
        .Latency (RespLatency)
    ) u_data_pipe (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .resp_i (data_resp_d),
        .resp_o (data_pipe_s)
    );

    // Outstanding counters: an accept and a response in one cycle cancel out.
    always_comb begin
        instr_cnt_d = instr_cnt_q;
        if (instr_acc_s && !instr_pipe_s.valid) begin
            instr_cnt_d = instr_cnt_q + CntOne;
        end else if (!instr_acc_s && instr_pipe_s.valid) begin
            instr_cnt_d = instr_cnt_q - CntOne;
        end else begin
            instr_cnt_d = instr_cnt_q;
        end
        data_cnt_d = data_cnt_q;
        if (data_acc_s && !data_pipe_s.valid) begin
            data_cnt_d = data_cnt_q + CntOne;
        end else if (!data_acc_s && data_pipe_s.valid) begin
            data_cnt_d = data_cnt_q - CntOne;
        end else begin
            data_cnt_d = data_cnt_q;
        end
    end

    // Error counter saturates; both ports may report an error together.
    always_comb begin
        err_inc_s   = {1'b0, instr_pipe_s.valid & instr_pipe_s.err}
                    + {1'b0, data_pipe_s.valid & data_pipe_s.err};
        err_sum_s   = {1'b0, err_count_q} + {15'd0, err_inc_s};
        if (err_sum_s[16]) begin
            err_count_d = 16'hFFFF;
        end else begin
            err_count_d = err_sum_s[15:0];
        end
    end

    // Counter state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instr_cnt_q <= '0;
            data_cnt_q  <= '0;
            err_count_q <= 16'd0;
        end else begin
            instr_cnt_q <= instr_cnt_d;
            data_cnt_q  <= data_cnt_d;
            err_count_q <= err_count_d;
        end
    end

    assign instr_rvalid_o = instr_pipe_s.valid;
    assign instr_err_o    = instr_pipe_s.err;
    assign instr_rdata_o  = instr_pipe_s.rdata[31:0];
    assign data_rvalid_o  = data_pipe_s.valid;
    assign data_err_o     = data_pipe_s.err;
    assign data_rdata_o   = data_pipe_s.rdata[DataWidth-1:0];
    assign err_count_o    = err_count_q;

    // The instruction port has no tag output; data has none when DataWidth is 32.
    assign rdata_unused_s = instr_pipe_s.rdata[32] ^ data_pipe_s.rdata[32];

endmodule

// File: tb/tb_tr_dual_port_mem.sv
// Scoreboard bench for tr_dual_port_mem: directed scenarios plus random
// traffic checked against a word-array reference model.
module tb_tr_dual_port_mem;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 256;
    localparam int          LAT   = 3;
    localparam int          MAXO  = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        instr_stall_i = 1'b0, data_stall_i = 1'b0;
    logic        instr_req_i = 1'b0, instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_addr_i = '0, instr_rdata_o;
    logic        data_req_i = 1'b0, data_gnt_o, data_rvalid_o, data_we_i = 1'b0, data_err_o;
    logic [3:0]  data_be_i = '0;
    logic [31:0] data_addr_i = '0;
    logic [32:0] data_wdata_i = '0, data_rdata_o;
    logic [15:0] err_count_o;

    tr_dual_port_mem #(
        .BaseAddr(BASE), .Depth(DEPTH), .DataWidth(33),
        .RespLatency(LAT), .MaxOutstanding(MAXO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .instr_stall_i(instr_stall_i), .data_stall_i(data_stall_i),
        .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
        .instr_addr_i(instr_addr_i), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
        .data_we_i(data_we_i), .data_be_i(data_be_i), .data_addr_i(data_addr_i),
        .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .err_count_o(err_count_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [32:0] rdata;
        bit          err;
        int          due;
    } exp_t;

    exp_t        iq[$];
    exp_t        dq[$];
    int          ihist[$];
    int          dhist[$];
    logic [32:0] mem_m [DEPTH];
    int          vectors = 0;
    int          miscompares = 0;
    int          err_model = 0;
    exp_t        ie, de;
    bit          ie_v, de_v;
    bit          g0, g1, g2, gi, gd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] addr);
        longint a;
        a = longint'(addr);
        return (a >= longint'(BASE)) && (a < longint'(BASE) + 4 * DEPTH);
    endfunction

    // Requests accepted in cycle a are counted by the responder in cycles a+1 .. a+LAT.
    function automatic int inflight(input int h[$]);
        int n;
        n = 0;
        foreach (h[k]) if (h[k] >= cyc - LAT && h[k] < cyc) n++;
        return n;
    endfunction

    function automatic exp_t instr_model(input logic [31:0] addr);
        exp_t e;
        e.due = cyc + LAT;
        e.err = !in_rng(addr);
        e.rdata = e.err ? 33'd0 : mem_m[int'((addr - BASE) >> 2)];
        return e;
    endfunction

    function automatic exp_t data_model(input bit we, input logic [3:0] be,
                                        input logic [31:0] addr, input logic [32:0] wd);
        exp_t e;
        int   idx;
        e.due = cyc + LAT;
        e.rdata = 33'd0;
        e.err = !in_rng(addr);
        if (!e.err) begin
            idx = int'((addr - BASE) >> 2);
            if (!we) begin
                e.rdata = mem_m[idx];
            end else begin
                for (int b = 0; b < 4; b++) if (be[b]) mem_m[idx][8*b +: 8] = wd[8*b +: 8];
                mem_m[idx][32] = (be == 4'hF) ? wd[32] : 1'b0;
            end
        end
        return e;
    endfunction

    // Monitor: compare whatever the DUT presents against the scoreboard heads.
    always @(negedge clk_i) begin
        while (iq.size() > 0 && iq[0].due < cyc) void'(iq.pop_front());
        while (dq.size() > 0 && dq[0].due < cyc) void'(dq.pop_front());
        ie_v = (iq.size() > 0) && (iq[0].due == cyc);
        de_v = (dq.size() > 0) && (dq[0].due == cyc);
        check("instr_rvalid", instr_rvalid_o, ie_v);
        check("data_rvalid", data_rvalid_o, de_v);
        if (ie_v) begin
            ie = iq.pop_front();
            if (ie.err) err_model++;
            if (instr_rvalid_o) begin
                check("instr_rdata", instr_rdata_o, ie.rdata[31:0]);
                check("instr_err", instr_err_o, ie.err);
            end
        end
        if (de_v) begin
            de = dq.pop_front();
            if (de.err) err_model++;
            if (data_rvalid_o) begin
                check("data_rdata", data_rdata_o, de.rdata);
                check("data_err", data_err_o, de.err);
            end
        end
    end

    task automatic cycle(input bit ireq, input logic [31:0] iaddr, input bit istall,
                         input bit dreq, input bit dwe, input logic [3:0] dbe,
                         input logic [31:0] daddr, input logic [32:0] dwd, input bit dstall,
                         output bit igot, output bit dgot);
        bit ig_e, dg_e;
        @(negedge clk_i);
        instr_req_i = ireq; instr_addr_i = iaddr; instr_stall_i = istall;
        data_req_i = dreq; data_we_i = dwe; data_be_i = dbe;
        data_addr_i = daddr; data_wdata_i = dwd; data_stall_i = dstall;
        #4;
        ig_e = ireq && !istall && (inflight(ihist) < MAXO);
        dg_e = dreq && !dstall && (inflight(dhist) < MAXO);
        check("instr_gnt", instr_gnt_o, ig_e);
        check("data_gnt", data_gnt_o, dg_e);
        igot = instr_gnt_o & ireq;
        dgot = data_gnt_o & dreq;
        if (ig_e) begin
            ihist.push_back(cyc);
            iq.push_back(instr_model(iaddr));
        end
        if (dg_e) begin
            dhist.push_back(cyc);
            dq.push_back(data_model(dwe, dbe, daddr, dwd));
        end
    endtask

    task automatic idle(input int n);
        bit a, b;
        repeat (n) cycle(0, '0, 0, 0, 0, '0, '0, '0, 0, a, b);
    endtask

    task automatic dxfer(input bit we, input logic [3:0] be, input logic [31:0] addr, input logic [32:0] wd);
        bit a, got;
        got = 0;
        for (int t = 0; t < 20 && !got; t++) cycle(0, '0, 0, 1, we, be, addr, wd, 0, a, got);
        if (!got) check("data_grant_timeout", got, 1);
    endtask

    task automatic ixfer(input logic [31:0] addr);
        bit b, got;
        got = 0;
        for (int t = 0; t < 20 && !got; t++) cycle(1, addr, 0, 0, 0, '0, '0, '0, 0, got, b);
        if (!got) check("instr_grant_timeout", got, 1);
    endtask

    task automatic drain();
        for (int t = 0; t < 40 && (iq.size() > 0 || dq.size() > 0); t++) idle(1);
        idle(1);
        check("drain_left", iq.size() + dq.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int w = 0; w < DEPTH; w++) mem_m[w] = 33'd0;
        // Reset state.
        repeat (2) @(negedge clk_i);
        #1;
        check("rst_instr_rvalid", instr_rvalid_o, 0);
        check("rst_data_rvalid", data_rvalid_o, 0);
        check("rst_data_rdata", data_rdata_o, 0);
        check("rst_instr_rdata", instr_rdata_o, 0);
        check("rst_errs", {instr_err_o, data_err_o}, 0);
        check("rst_err_count", err_count_o, 0);
        check("rst_gnts", {instr_gnt_o, data_gnt_o}, 0);
        #1 rst_ni = 1'b1;

        // Known contents for every word the bench touches.
        for (int w = 0; w < 32; w++) dxfer(1, 4'hF, BASE + 32'(4 * w), 33'd0);
        dxfer(1, 4'hF, BASE + 32'(4 * (DEPTH - 1)), 33'd0);
        drain();

        // Back-to-back reads stop at the outstanding limit.
        cycle(0, '0, 0, 1, 0, 4'hF, 32'h8000_0000, '0, 0, gi, g0);
        cycle(0, '0, 0, 1, 0, 4'hF, 32'h8000_0004, '0, 0, gi, g1);
        cycle(0, '0, 0, 1, 0, 4'hF, 32'h8000_0008, '0, 0, gi, g2);
        check("b2b_gnt0", g0, 1);
        check("b2b_gnt1", g1, 1);
        check("b2b_gnt2", g2, 0);
        drain();

        // Full write with tag, then a partial write that clears the tag.
        dxfer(1, 4'hF, 32'h8000_0010, 33'h1_DEAD_BEEF);
        dxfer(0, 4'hF, 32'h8000_0010, '0);
        dxfer(1, 4'b0001, 32'h8000_0010, 33'h0_0000_0055);
        dxfer(0, 4'hF, 32'h8000_0010, '0);
        drain();

        // Instruction read and data write to the same word in one cycle.
        dxfer(1, 4'hF, 32'h8000_0020, 33'h0_1111_1111);
        drain();
        cycle(1, 32'h8000_0020, 0, 1, 1, 4'hF, 32'h8000_0020, 33'h0_2222_2222, 0, gi, gd);
        check("rbw_both_gnt", {gi, gd}, 2'b11);
        ixfer(32'h8000_0020);
        drain();

        // Grant suppression while stalled, immediate grant on release.
        for (int s = 0; s < 5; s++) begin
            cycle(0, '0, 0, 1, 0, 4'hF, 32'h8000_0004, '0, 1, gi, gd);
            check("stall_gnt", gd, 0);
        end
        cycle(0, '0, 0, 1, 0, 4'hF, 32'h8000_0004, '0, 0, gi, gd);
        check("unstall_gnt", gd, 1);
        drain();

        // Reset with requests in flight.
        cycle(1, 32'h8000_0000, 0, 1, 0, 4'hF, 32'h8000_0004, '0, 0, gi, gd);
        cycle(0, '0, 0, 1, 0, 4'hF, 32'h8000_0008, '0, 0, gi, gd);
        @(negedge clk_i);
        instr_req_i = 0; data_req_i = 0;
        #2 rst_ni = 1'b0;
        iq.delete(); dq.delete(); ihist.delete(); dhist.delete();
        err_model = 0;
        #1;
        check("midrst_rvalids", {instr_rvalid_o, data_rvalid_o}, 0);
        check("midrst_err_count", err_count_o, 0);
        @(negedge clk_i);
        #2 rst_ni = 1'b1;
        idle(LAT + 2);
        cycle(1, 32'h8000_0000, 0, 1, 0, 4'hF, 32'h8000_0000, '0, 0, gi, gd);
        check("post_rst_gnt", {gi, gd}, 2'b11);
        drain();

        // Address-range errors.
        dxfer(0, 4'hF, 32'h7FFF_FFFC, '0);
        dxfer(1, 4'hF, BASE + 32'(4 * DEPTH), 33'h1_2345_6789);
        dxfer(0, 4'hF, BASE, '0);
        dxfer(0, 4'hF, BASE + 32'(4 * (DEPTH - 1)), '0);
        drain();
        check("err_count_two", err_count_o, 2);

        // Random mixed traffic on both ports.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ia, da;
            ia = BASE + 32'($urandom_range(0, 31) * 4) + 32'($urandom_range(0, 3));
            da = BASE + 32'($urandom_range(0, 31) * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) ia = BASE - 32'(4 * $urandom_range(1, 4));
            if ($urandom_range(0, 7) == 0) da = BASE + 32'(4 * (DEPTH + $urandom_range(0, 4)));
            cycle($urandom_range(0, 1) == 1, ia, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 4) < 3, $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15)),
                  da, {1'($urandom_range(0, 1)), 32'($urandom)}, $urandom_range(0, 4) == 0,
                  gi, gd);
        end
        drain();
        check("err_count_final", err_count_o, err_model);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
